alu_flag_stage: RTL and testbench

- Pipeline stage directly downstream of the add/subtract unit.
- Registers the ALU result and its Z/V/N/C flags behind a valid/ready handshake with a 2-entry skid buffer.
- Evaluates a 3-bit branch condition on the operation's own flags and produces a taken bit.
- Maintains an architectural flag register for later reads by the control unit.

---
 rtl/alu_flag_stage_pkg.sv | 36 +++
 rtl/alu_flag_stage_skid_buffer.sv | 71 +++++++
 rtl/alu_flag_stage.sv | 79 +++++++
 tb/tb_alu_flag_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_stage_pkg.sv
// Shared constants and helpers for the ALU flag stage: condition codes and
// flag bit positions within the {c,v,n,z} flag nibble.
package alu_flag_stage_pkg;

   localparam int unsigned COND_W  = 3;
   localparam int unsigned FLAGS_W = 4;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_C = 3;

   typedef enum logic [COND_W-1:0] {
      COND_NEVER = 3'd0,
      COND_ALWAYS = 3'd1,
      COND_EQ = 3'd2,
      COND_NE = 3'd3,
      COND_LT = 3'd4,
      COND_GE = 3'd5,
      COND_LTU = 3'd6,
      COND_GEU = 3'd7
   } cond_e;

   // Place individual flags at their architectural bit positions.
   function automatic logic [FLAGS_W-1:0] pack_flags(input logic c, input logic v,
                                                     input logic n, input logic z);
      logic [FLAGS_W-1:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_flag_stage_skid_buffer.sv
// Generic two-entry valid/ready buffer: main register drives the outputs,
// skid register absorbs one beat of overflow so in_ready can be registered.
module alu_flag_stage_skid_buffer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              s_valid;
   logic [DATA_W-1:0] s_data;

   logic              m_valid_nxt;
   logic [DATA_W-1:0] m_data_nxt;
   logic              s_valid_nxt;
   logic [DATA_W-1:0] s_data_nxt;
   logic              acc;
   logic              emit;

   assign acc  = in_valid && in_ready;
   assign emit = out_valid && out_ready;

   // Next-state for both entries; S only fills while M is stalled.
   always_comb begin
      m_valid_nxt = out_valid;
      m_data_nxt  = out_data;
      s_valid_nxt = s_valid;
      s_data_nxt  = s_data;
      if (!out_valid) begin
         if (acc) begin
            m_valid_nxt = 1'b1;
            m_data_nxt  = in_data;
         end
      end else if (emit) begin
         if (s_valid) begin
            m_data_nxt  = s_data;
            s_valid_nxt = 1'b0;
         end else if (acc) begin
            m_data_nxt = in_data;
         end else begin
            m_valid_nxt = 1'b0;
         end
      end else if (acc) begin
         s_valid_nxt = 1'b1;
         s_data_nxt  = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         s_valid   <= 1'b0;
         s_data    <= '0;
         in_ready  <= 1'b1;
      end else begin
         out_valid <= m_valid_nxt;
         out_data  <= m_data_nxt;
         s_valid   <= s_valid_nxt;
         s_data    <= s_data_nxt;
         in_ready  <= !s_valid_nxt;
      end
   end

endmodule

// File: rtl/alu_flag_stage.sv
// Stage after the add/sub unit: buffers result+flags, evaluates the branch
// condition on the operation's own flags, and keeps the architectural flags.
module alu_flag_stage
   import alu_flag_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_result,
   input  logic               in_z,
   input  logic               in_v,
   input  logic               in_n,
   input  logic               in_c,
   input  logic [COND_W-1:0]  in_cond,
   input  logic               in_flag_we,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_taken,
   output logic [FLAGS_W-1:0] out_flags,
   output logic [FLAGS_W-1:0] flags_q
);

   localparam int unsigned PAYLOAD_W = WIDTH + 1 + FLAGS_W;

   logic [FLAGS_W-1:0]   in_flags;
   logic                 taken;
   logic                 acc;
   logic [PAYLOAD_W-1:0] in_payload;
   logic [PAYLOAD_W-1:0] out_payload;

   // Branch condition decode on the incoming beat's flags.
   always_comb begin
      in_flags = pack_flags(in_c, in_v, in_n, in_z);
      taken    = 1'b0;
      case (cond_e'(in_cond))
         COND_NEVER:  taken = 1'b0;
         COND_ALWAYS: taken = 1'b1;
         COND_EQ:     taken = in_flags[FLAG_Z];
         COND_NE:     taken = !in_flags[FLAG_Z];
         COND_LT:     taken = in_flags[FLAG_N] ^ in_flags[FLAG_V];
         COND_GE:     taken = !(in_flags[FLAG_N] ^ in_flags[FLAG_V]);
         COND_LTU:    taken = !in_flags[FLAG_C];
         COND_GEU:    taken = in_flags[FLAG_C];
         default:     taken = 1'b0;
      endcase
   end

   assign in_payload = {in_result, taken, in_flags};
   assign acc        = in_valid && in_ready;

   alu_flag_stage_skid_buffer #(
      .DATA_W(PAYLOAD_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_payload),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_payload)
   );

   assign {out_result, out_taken, out_flags} = out_payload;

   // Architectural flags follow acceptance, not emission.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else if (acc && in_flag_we) begin
         flags_q <= in_flags;
      end
   end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage: condition decode, backpressure ordering,
// flag-register gating and asynchronous reset.
module tb_alu_flag_stage;
   import alu_flag_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_z, in_v, in_n, in_c;
   logic [2:0]  in_cond;
   logic        in_flag_we;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_taken;
   logic [3:0]  out_flags;
   logic [3:0]  flags_q;

   int n_tests = 0;
   int n_fail  = 0;

   alu_flag_stage #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_z      (in_z),
      .in_v      (in_v),
      .in_n      (in_n),
      .in_c      (in_c),
      .in_cond   (in_cond),
      .in_flag_we(in_flag_we),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_taken (out_taken),
      .out_flags (out_flags),
      .flags_q   (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_nib(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] r, input logic z, input logic v, input logic n,
                       input logic c, input logic [2:0] cond, input logic we);
      in_valid   = 1'b1;
      in_result  = r;
      in_z       = z;
      in_v       = v;
      in_n       = n;
      in_c       = c;
      in_cond    = cond;
      in_flag_we = we;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_result = '0; in_z = 1'b0; in_v = 1'b0; in_n = 1'b0;
      in_c = 1'b0; in_cond = '0; in_flag_we = 1'b0; out_ready = 1'b1;
      #1;
      chk_bit ("rst_out_valid", out_valid, 1'b0);
      chk_bit ("rst_in_ready", in_ready, 1'b1);
      chk_nib ("rst_flags_q", flags_q, 4'b0000);
      chk_word("rst_out_result", out_result, 16'h0000);
      chk_bit ("rst_out_taken", out_taken, 1'b0);
      chk_nib ("rst_out_flags", out_flags, 4'b0000);
      tick(); tick();
      rst = 1'b0;

      // 5-3 = 2: GE taken, LT not
      send(16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, COND_GE, 1'b1);
      tick();
      chk_bit ("53_valid", out_valid, 1'b1);
      chk_word("53_result", out_result, 16'h0002);
      chk_bit ("53_ge", out_taken, 1'b1);
      chk_nib ("53_flags", out_flags, 4'b1000);
      chk_nib ("53_flags_q", flags_q, 4'b1000);
      send(16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, COND_LT, 1'b0);
      tick();
      chk_bit ("53_lt_valid", out_valid, 1'b1);
      chk_bit ("53_lt", out_taken, 1'b0);

      // 3-5 = -2: LTU, LT taken; GEU not
      send(16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, COND_LTU, 1'b0);
      tick();
      chk_word("35_result", out_result, 16'hFFFE);
      chk_bit ("35_ltu", out_taken, 1'b1);
      chk_nib ("35_flags", out_flags, 4'b0010);
      send(16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, COND_LT, 1'b0);
      tick();
      chk_bit ("35_lt", out_taken, 1'b1);
      send(16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, COND_GEU, 1'b0);
      tick();
      chk_bit ("35_geu", out_taken, 1'b0);

      // 0x7FFF - 0xFFFF = 0x8000 with overflow: GE taken, LT not
      send(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, COND_GE, 1'b0);
      tick();
      chk_bit ("ovf_ge", out_taken, 1'b1);
      chk_nib ("ovf_flags", out_flags, 4'b0110);
      send(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, COND_LT, 1'b0);
      tick();
      chk_bit ("ovf_lt", out_taken, 1'b0);

      // zero result: EQ/NE/NEVER/ALWAYS
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, COND_EQ, 1'b0);
      tick();
      chk_bit ("z_eq", out_taken, 1'b1);
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, COND_NE, 1'b0);
      tick();
      chk_bit ("z_ne", out_taken, 1'b0);
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, COND_NEVER, 1'b0);
      tick();
      chk_bit ("z_never", out_taken, 1'b0);
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, COND_ALWAYS, 1'b0);
      tick();
      chk_bit ("z_always", out_taken, 1'b1);
      chk_nib ("flags_q_held", flags_q, 4'b1000);
      in_valid = 1'b0;
      tick();
      chk_bit ("drain_valid", out_valid, 1'b0);

      // backpressure: A, B, C with out_ready low
      out_ready = 1'b0;
      send(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, COND_NEVER, 1'b0);
      tick();
      chk_word("bp_a_in_m", out_result, 16'h1111);
      chk_bit ("bp_ready_after_a", in_ready, 1'b1);
      send(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, COND_NEVER, 1'b0);
      tick();
      chk_word("bp_a_held", out_result, 16'h1111);
      chk_bit ("bp_ready_after_b", in_ready, 1'b0);
      send(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, COND_NEVER, 1'b0);
      tick();
      chk_word("bp_stall1", out_result, 16'h1111);
      chk_bit ("bp_stall1_ready", in_ready, 1'b0);
      tick();
      chk_word("bp_stall2", out_result, 16'h1111);
      chk_bit ("bp_stall2_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick();
      chk_word("bp_out_b", out_result, 16'h2222);
      chk_bit ("bp_ready_back", in_ready, 1'b1);
      tick();
      chk_word("bp_out_c", out_result, 16'h3333);
      chk_bit ("bp_c_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_bit ("bp_drained", out_valid, 1'b0);

      // flag write-enable gating from a clean reset
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      send(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, COND_EQ, 1'b0);
      tick();
      chk_nib ("we0_flags_q", flags_q, 4'b0000);
      chk_nib ("we0_out_flags", out_flags, 4'b0001);
      send(16'h9000, 1'b0, 1'b0, 1'b1, 1'b1, COND_EQ, 1'b1);
      tick();
      chk_nib ("we1_flags_q", flags_q, 4'b1010);

      // reset mid-operation with both entries full
      out_ready = 1'b0;
      send(16'h4444, 1'b0, 1'b1, 1'b0, 1'b1, COND_ALWAYS, 1'b1);
      tick();
      send(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, COND_ALWAYS, 1'b0);
      tick();
      chk_bit ("full_ready", in_ready, 1'b0);
      chk_nib ("full_flags_q", flags_q, 4'b1100);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_bit ("arst_valid", out_valid, 1'b0);
      chk_bit ("arst_ready", in_ready, 1'b1);
      chk_nib ("arst_flags_q", flags_q, 4'b0000);
      chk_word("arst_result", out_result, 16'h0000);
      #3 rst = 1'b0;
      out_ready = 1'b1;
      send(16'h6666, 1'b0, 1'b0, 1'b0, 1'b1, COND_GEU, 1'b0);
      tick();
      chk_bit ("post_valid", out_valid, 1'b1);
      chk_word("post_result", out_result, 16'h6666);
      chk_bit ("post_taken", out_taken, 1'b1);
      in_valid = 1'b0;
      tick();
      chk_bit ("post_drain", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
